// File: rtl/ldpc_3gpp_enc_types_pkg.sv
// Shared LDPC 3GPP encoder types.
//   hb_zc_t     : expansion factor / word width (fits Zc up to 384)
//   strb_t      : frame/packet strobes travelling with Hb table reads
//   p3_state_t  : p3 controller FSM states
//   ceil_div    : ceil(n/d); a zero divisor is treated as 1 and the
//                 result is held at 1 or more, so that a job always has a word
package ldpc_3gpp_enc_types_pkg;

  localparam int cZC_W       = 9;
  localparam int cZC_MAX     = 384;
  localparam int cHB_ROW_MIN = 1;
  localparam int cHB_ROW_MAX = 46;

  typedef logic [cZC_W-1:0] hb_zc_t;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
  } strb_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} p3_state_t;

  localparam logic [cZC_W:0] cONE = 1;

  function automatic logic [cZC_W:0] ceil_div(input hb_zc_t n, input hb_zc_t d);
    logic [cZC_W:0] dd;
    logic [cZC_W:0] q;
    dd = (d == '0) ? cONE : {1'b0, d};
    q  = ({1'b0, n} + dd - cONE) / dd;
    return (q == '0) ? cONE : q;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_nwords_calc.sv
// Registered words-per-row calculator: onwords = ceil(izc / W).
// W is pDAT_W, or idat_w when pUSE_VAR_DAT_W=1. The result is captured
// only on iload, so it stays fixed for the whole job.
//   iclk, ireset (sync, high), iclkena : clocking
//   iload                              : capture pulse (job start)
//   izc, idat_w                        : expansion factor, variable width
//   onwords                            : latched word count (1 tick latency)
module ldpc_3gpp_enc_nwords_calc
  import ldpc_3gpp_enc_types_pkg::*;
#(
  parameter int pADDR_W        = 8,
  parameter int pDAT_W         = 8,
  parameter int pUSE_VAR_DAT_W = 0
)(
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               iload,
  input  hb_zc_t             izc,
  input  hb_zc_t             idat_w,
  output logic [pADDR_W-1:0] onwords
);

  hb_zc_t             w_dat_w;
  logic [cZC_W:0]     w_q;
  logic [pADDR_W-1:0] r_nwords;

  assign w_dat_w = (pUSE_VAR_DAT_W != 0) ? idat_w : hb_zc_t'(pDAT_W);
  assign w_q     = ceil_div(izc, w_dat_w);
  assign onwords = r_nwords;

  always_ff @(posedge iclk) begin
    if (ireset)                r_nwords <= '0;
    else if (iclkena && iload) r_nwords <= pADDR_W'(w_q);
  end

endmodule

// File: rtl/ldpc_3gpp_enc_p3_ctrl.sv
// LDPC 3GPP encoder p3 controller. A job writes nwords p2 words, then
// reads the Hb table row-major (irow_num rows x nwords words), then waits
// for irow_num*nwords datapath outputs before pulsing odone.
//   iclk, ireset (sync, high), iclkena   : clocking
//   iused_zc, iused_dat_w, irow_num      : job geometry, latched on istart
//   istart, iwval, irval_p3              : job start, p2 word valid, p3 out valid
//   obusy, odone, oerr                   : status (oerr sticky until reset)
//   owrite4p2, owstart4p2                : p2 write strobes
//   ohb_raddr                            : Hb row address (table has 1-tick latency)
//   oread, orstart, orval, orstrb        : read controls, aligned with table data
module ldpc_3gpp_enc_p3_ctrl
  import ldpc_3gpp_enc_types_pkg::*;
#(
  parameter int pADDR_W        = 8,
  parameter int pDAT_W         = 8,
  parameter int pUSE_VAR_DAT_W = 0,
  parameter int pROW_W         = 6
)(
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  hb_zc_t            iused_zc,
  input  hb_zc_t            iused_dat_w,
  input  logic [pROW_W-1:0] irow_num,
  input  logic              istart,
  input  logic              iwval,
  output logic              obusy,
  output logic              odone,
  output logic              oerr,
  output logic              owrite4p2,
  output logic              owstart4p2,
  output logic [pROW_W-1:0] ohb_raddr,
  output logic              oread,
  output logic              orstart,
  output logic              orval,
  output strb_t             orstrb,
  input  logic              irval_p3
);

  localparam int cCNT_W = pADDR_W + pROW_W;

  p3_state_t          r_state, w_next;
  logic [pROW_W-1:0]  r_rows, r_row;
  logic [pADDR_W-1:0] r_word, w_nwords;
  logic [cCNT_W-1:0]  r_dcnt, w_total;
  logic               r_err, r_oread, r_orstart;
  strb_t              r_strb;
  logic               w_start, w_wr, w_wlast, w_rlast, w_zero_rows;
  logic               w_drained, w_done, w_err_set, w_in_read;

  ldpc_3gpp_enc_nwords_calc #(
    .pADDR_W(pADDR_W), .pDAT_W(pDAT_W), .pUSE_VAR_DAT_W(pUSE_VAR_DAT_W)
  ) u_nwords (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iload(w_start),
    .izc(iused_zc), .idat_w(iused_dat_w), .onwords(w_nwords)
  );

  assign w_in_read   = (r_state == READ);
  assign w_start     = iclkena & istart & (r_state == IDLE);
  assign w_wr        = iclkena & iwval & (r_state == WRITE);
  assign w_wlast     = (r_word == w_nwords - pADDR_W'(1));
  assign w_rlast     = (r_row == r_rows - pROW_W'(1));
  assign w_zero_rows = (r_rows == '0);
  assign w_total     = cCNT_W'(r_rows) * cCNT_W'(w_nwords);
  assign w_drained   = (r_dcnt == w_total);
  // A zero-row job ends on its last write; a normal job ends once drained.
  assign w_done      = (w_wr & w_wlast & w_zero_rows) |
                       (iclkena & (r_state == DRAIN) & w_drained);
  // istart in the done tick is dropped silently: the block is already idle
  // from the outside's point of view.
  assign w_err_set   = iclkena & ((istart & (r_state != IDLE) & ~w_done) |
                                  (iwval & (r_state != WRITE)) |
                                  (w_wr & w_wlast & w_zero_rows));

  // state register
  always_ff @(posedge iclk) begin
    if (ireset)       r_state <= IDLE;
    else if (iclkena) r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (istart) w_next = WRITE;
      WRITE:   if (iwval && w_wlast) w_next = w_zero_rows ? IDLE : READ;
      READ:    if (w_wlast && w_rlast) w_next = DRAIN;
      DRAIN:   if (w_drained) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    obusy      = (r_state != IDLE);
    owrite4p2  = w_wr;
    owstart4p2 = w_wr & (r_word == '0);
    odone      = w_done;
  end

  assign oerr      = r_err;
  assign ohb_raddr = r_row;
  assign oread     = r_oread;
  assign orval     = r_oread;
  assign orstart   = r_orstart;
  assign orstrb    = r_strb;

  // counters and the one-tick read pipeline that lines up with table data
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_rows    <= '0;
      r_row     <= '0;
      r_word    <= '0;
      r_dcnt    <= '0;
      r_err     <= 1'b0;
      r_oread   <= 1'b0;
      r_orstart <= 1'b0;
      r_strb    <= '0;
    end else if (iclkena) begin
      r_err      <= r_err | w_err_set;
      r_oread    <= w_in_read;
      r_orstart  <= w_in_read & (r_word == '0);
      r_strb.sof <= w_in_read & (r_row == '0) & (r_word == '0);
      r_strb.sop <= w_in_read & (r_word == '0);
      r_strb.eop <= w_in_read & w_wlast;
      r_strb.eof <= w_in_read & w_wlast & w_rlast;
      case (r_state)
        IDLE: if (istart) begin
          r_rows <= irow_num;
          r_row  <= '0;
          r_word <= '0;
          r_dcnt <= '0;
        end
        WRITE: if (iwval) r_word <= w_wlast ? '0 : r_word + pADDR_W'(1);
        READ: begin
          if (w_wlast) begin
            r_word <= '0;
            r_row  <= w_rlast ? '0 : r_row + pROW_W'(1);
          end else begin
            r_word <= r_word + pADDR_W'(1);
          end
        end
        default: ;
      endcase
      // Datapath results may come back while reads are still being issued.
      if ((r_state == READ || r_state == DRAIN) && irval_p3 && !w_drained)
        r_dcnt <= r_dcnt + cCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ldpc_3gpp_enc_p3_ctrl.sv
module tb_ldpc_3gpp_enc_p3_ctrl;
  import ldpc_3gpp_enc_types_pkg::*;

  localparam int AW = 8;
  localparam int RW = 6;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic ireset = 1'b1, iclkena = 1'b1, istart = 1'b0, iwval = 1'b0, irval_p3 = 1'b0;
  hb_zc_t iused_zc = '0, iused_dat_w = '0;
  logic [RW-1:0] irow_num = '0;
  logic obusy, odone, oerr, owrite4p2, owstart4p2, oread, orstart, orval;
  logic [RW-1:0] ohb_raddr;
  strb_t orstrb;

  ldpc_3gpp_enc_p3_ctrl #(
    .pADDR_W(AW), .pDAT_W(8), .pUSE_VAR_DAT_W(1), .pROW_W(RW)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iused_zc(iused_zc), .iused_dat_w(iused_dat_w), .irow_num(irow_num),
    .istart(istart), .iwval(iwval), .obusy(obusy), .odone(odone), .oerr(oerr),
    .owrite4p2(owrite4p2), .owstart4p2(owstart4p2), .ohb_raddr(ohb_raddr),
    .oread(oread), .orstart(orstart), .orval(orval), .orstrb(orstrb),
    .irval_p3(irval_p3)
  );

  typedef struct { int zc; int dw; int rows; bit tog; int nw; int nrd; } vec_t;
  typedef struct packed { logic [RW-1:0] row; logic rstart; strb_t strb; } rd_t;

  vec_t vecs[7];
  rd_t  sb[$];
  int n_tests = 0, n_fail = 0;
  int c_wr = 0, c_ws = 0, c_rd = 0, c_rs = 0, c_sof = 0, c_eof = 0, c_done = 0, c_rv = 0;
  int rv_pend = 0;
  bit tog = 1'b0;
  logic [RW-1:0] last_raddr = '0;

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor + datapath echo: every read seen comes back later as irval_p3.
  always @(negedge iclk) begin
    rd_t e;
    if (!ireset && iclkena) begin
      if (owrite4p2)  c_wr++;
      if (owstart4p2) c_ws++;
      if (irval_p3) begin c_rv++; if (rv_pend > 0) rv_pend--; end
      if (oread) begin
        c_rd++; rv_pend++;
        if (orstart)    c_rs++;
        if (orstrb.sof) c_sof++;
        if (orstrb.eof) c_eof++;
        if (sb.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("rd_row",    int'(last_raddr), int'(e.row));
          check("rd_rstart", int'(orstart),    int'(e.rstart));
          check("rd_strb",   int'(orstrb),     int'(e.strb));
          check("rd_orval",  int'(orval),      1);
        end
      end
      if (odone) c_done++;
      last_raddr = ohb_raddr;
    end
  end

  task automatic step();
    @(posedge iclk); #1;
    iclkena  = tog ? ~iclkena : 1'b1;
    irval_p3 = (rv_pend > 0);
    istart   = 1'b0;
    iwval    = 1'b0;
  endtask

  task automatic chk_idle(input string t);
    check({t, "_obusy"},   int'(obusy),      0);
    check({t, "_odone"},   int'(odone),      0);
    check({t, "_oerr"},    int'(oerr),       0);
    check({t, "_owrite"},  int'(owrite4p2),  0);
    check({t, "_owstart"}, int'(owstart4p2), 0);
    check({t, "_oread"},   int'(oread),      0);
    check({t, "_orstart"}, int'(orstart),    0);
    check({t, "_orval"},   int'(orval),      0);
    check({t, "_orstrb"},  int'(orstrb),     0);
    check({t, "_raddr"},   int'(ohb_raddr),  0);
  endtask

  task automatic begin_job(input int zc, input int dw, input int rows, input int nw);
    rd_t e;
    c_wr = 0; c_ws = 0; c_rd = 0; c_rs = 0; c_sof = 0; c_eof = 0; c_done = 0; c_rv = 0;
    for (int r = 0; r < rows; r++)
      for (int w = 0; w < nw; w++) begin
        e.row      = RW'(r);
        e.rstart   = (w == 0);
        e.strb.sof = (r == 0 && w == 0);
        e.strb.sop = (w == 0);
        e.strb.eop = (w == nw - 1);
        e.strb.eof = (r == rows - 1 && w == nw - 1);
        sb.push_back(e);
      end
    step();
    iused_zc = hb_zc_t'(zc); iused_dat_w = hb_zc_t'(dw); irow_num = RW'(rows); istart = 1'b1;
    for (int i = 0; i < nw; i++) begin step(); iwval = 1'b1; end
  endtask

  task automatic wait_done(input int bound, input bit inj);
    int n = 0;
    bit did = 1'b0;
    while (c_done == 0 && n < bound) begin
      step(); n++;
      if (inj && !did && c_rd == 2 && iclkena) begin istart = 1'b1; did = 1'b1; end
    end
    tog = 1'b0;
    step(); step();
    @(negedge iclk);
  endtask

  task automatic check_job(input string t, input int nw, input int nrd, input int rows, input int err);
    check({t, "_writes"}, c_wr,  nw);
    check({t, "_wstart"}, c_ws,  1);
    check({t, "_reads"},  c_rd,  nrd);
    check({t, "_rstart"}, c_rs,  rows);
    check({t, "_sof"},    c_sof, (rows > 0) ? 1 : 0);
    check({t, "_eof"},    c_eof, (rows > 0) ? 1 : 0);
    check({t, "_done"},   c_done, 1);
    check({t, "_rval"},   c_rv,  nrd);
    check({t, "_sb_left"}, sb.size(), 0);
    check({t, "_oerr"},   int'(oerr),  err);
    check({t, "_obusy"},  int'(obusy), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{384,  8, 4, 1'b0, 48, 192};
    vecs[1] = '{  8,  8, 1, 1'b0,  1,   1};
    vecs[2] = '{ 52, 16, 3, 1'b0,  4,  12};
    vecs[3] = '{384,  8, 4, 1'b1, 48, 192};
    vecs[4] = '{ 20,  8, 2, 1'b1,  3,   6};
    vecs[5] = '{  7,  8, 5, 1'b0,  1,   5};
    vecs[6] = '{130, 32, 2, 1'b0,  5,  10};

    repeat (3) @(posedge iclk);
    #1 ireset = 1'b0;
    @(negedge iclk);
    chk_idle("rst");

    foreach (vecs[i]) begin
      begin_job(vecs[i].zc, vecs[i].dw, vecs[i].rows, vecs[i].nw);
      tog = vecs[i].tog;
      wait_done(5000, 1'b0);
      check_job($sformatf("v%0d", i), vecs[i].nw, vecs[i].nrd, vecs[i].rows, 0);
    end

    // istart during READ, then iwval in IDLE: ignored, error sticky
    begin_job(24, 8, 2, 3);
    wait_done(2000, 1'b1);
    step(); iwval = 1'b1;
    step(); @(negedge iclk);
    check_job("err", 3, 6, 2, 1);

    // zero rows: done straight out of WRITE, error set
    begin_job(16, 8, 0, 2);
    wait_done(200, 1'b0);
    check_job("row0", 2, 0, 0, 1);

    // reset clears the sticky error
    step(); ireset = 1'b1;
    step(); ireset = 1'b0;
    @(negedge iclk);
    chk_idle("rst2");

    // abort on read 10
    begin_job(384, 8, 4, 48);
    n = 0;
    while (c_rd < 10 && n < 500) begin step(); n++; end
    check("abort_rd10", int'(c_rd >= 10), 1);
    step(); ireset = 1'b1; irval_p3 = 1'b0; rv_pend = 0; sb.delete();
    step(); ireset = 1'b0;
    @(negedge iclk);
    chk_idle("abort");
    repeat (5) step();
    check("abort_nodone", c_done, 0);
    begin_job(8, 8, 1, 1);
    wait_done(200, 1'b0);
    check_job("post", 1, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
